// File: rtl/counter_6bit_pkg.sv
// Shared sine-generator constants: LUT geometry and quarter-wave quadrant encoding.
package counter_6bit_pkg;

    localparam int unsigned LUT_ADDR_W = 6;
    localparam int unsigned LUT_DEPTH  = 64;
    localparam int unsigned QUAD_W     = 2;

    typedef enum logic [QUAD_W-1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } quadrant_e;

    // Quadrant advances once per completed sweep and rolls Q4 -> Q1 silently.
    function automatic quadrant_e next_quadrant(input quadrant_e q);
        return quadrant_e'(QUAD_W'(q) + QUAD_W'(1));
    endfunction

endpackage

// File: rtl/counter_6bit_if.sv
// Address/sweep bundle from the sine address counter to the LUT and quadrant controller.
interface counter_6bit_if
    import counter_6bit_pkg::*;
#(
    parameter int unsigned WIDTH = LUT_ADDR_W
);

    logic [WIDTH-1:0]  par_out;
    logic              tc;
    logic              wrap;
    logic [QUAD_W-1:0] wrap_count;

    modport master (
        output par_out,
        output tc,
        output wrap,
        output wrap_count
    );

    modport slave (
        input par_out,
        input tc,
        input wrap,
        input wrap_count
    );

endinterface

// File: rtl/counter_6bit.sv
// Free-running modulo-MODULUS address counter for the sine LUT, with terminal-count
// decode, a one-cycle wrap pulse and a 2-bit sweep (quadrant) counter.
module counter_6bit
    import counter_6bit_pkg::*;
#(
    parameter int unsigned WIDTH       = LUT_ADDR_W,
    parameter int unsigned MODULUS     = LUT_DEPTH,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic           clk,
    input  logic           rst,
    counter_6bit_if.master cnt
);

    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VALUE);

    // Reject parameter sets the counter cannot represent.
    generate
        if ((MODULUS < 2) || (64'(MODULUS) > (64'(1) << WIDTH))) begin : g_bad_modulus
            $error("counter_6bit: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
        if (RESET_VALUE >= MODULUS) begin : g_bad_reset_value
            $error("counter_6bit: RESET_VALUE must be below MODULUS");
        end
    endgenerate

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    quadrant_e        quad_q;
    quadrant_e        quad_d;
    logic             last_c;

    // Next-state: anything at or past the last count restarts the sweep.
    always_comb begin
        last_c  = (count_q >= LAST);
        count_d = count_q + WIDTH'(1);
        wrap_d  = 1'b0;
        quad_d  = quad_q;
        if (last_c) begin
            count_d = '0;
            wrap_d  = 1'b1;
            quad_d  = next_quadrant(quad_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_CNT;
            wrap_q  <= 1'b0;
            quad_q  <= Q1;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            quad_q  <= quad_d;
        end
    end

    assign cnt.par_out    = count_q;
    assign cnt.tc         = (count_q == LAST);
    assign cnt.wrap       = wrap_q;
    assign cnt.wrap_count = QUAD_W'(quad_q);

endmodule

// File: tb/tb_counter_6bit.sv
// Scoreboard bench for counter_6bit: a default 64-count instance and a MODULUS=10,
// RESET_VALUE=7 instance run side by side against a reference model.
module tb_counter_6bit;

    localparam int unsigned MOD_A = 64;
    localparam int unsigned RV_A  = 0;
    localparam int unsigned MOD_B = 10;
    localparam int unsigned RV_B  = 7;

    typedef struct {
        int par_a;
        int tc_a;
        int wrap_a;
        int wc_a;
        int par_b;
        int tc_b;
        int wrap_b;
        int wc_b;
    } exp_t;

    logic clk;
    logic rst;

    counter_6bit_if #(.WIDTH(6)) if_a ();
    counter_6bit_if #(.WIDTH(6)) if_b ();

    counter_6bit #(.WIDTH(6), .MODULUS(MOD_A), .RESET_VALUE(RV_A)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .cnt (if_a)
    );

    counter_6bit #(.WIDTH(6), .MODULUS(MOD_B), .RESET_VALUE(RV_B)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .cnt (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   wraps_a  = 0;
    int   cyc      = 0;

    int m_cnt_a = 0, m_wrap_a = 0, m_wc_a = 0;
    int m_cnt_b = 0, m_wrap_b = 0, m_wc_b = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Reference model for one edge of a modulo-m counter.
    task automatic model_adv(input bit r, input int m, input int rv,
                             inout int c, inout int w, inout int wc);
        if (r) begin
            c = rv; w = 0; wc = 0;
        end else if (c >= m - 1) begin
            c = 0; w = 1; wc = (wc + 1) % 4;
        end else begin
            c = c + 1; w = 0;
        end
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty cyc=%0d: got 0 entries expected 1", cyc);
        end else begin
            e = sb.pop_front();
            check_eq("par_a",  int'(if_a.par_out),    e.par_a);
            check_eq("tc_a",   int'(if_a.tc),         e.tc_a);
            check_eq("wrap_a", int'(if_a.wrap),       e.wrap_a);
            check_eq("wc_a",   int'(if_a.wrap_count), e.wc_a);
            check_eq("par_b",  int'(if_b.par_out),    e.par_b);
            check_eq("tc_b",   int'(if_b.tc),         e.tc_b);
            check_eq("wrap_b", int'(if_b.wrap),       e.wrap_b);
            check_eq("wc_b",   int'(if_b.wrap_count), e.wc_b);
        end
        if (if_a.wrap === 1'b1) wraps_a++;
    endtask

    // Drive rst for one edge, push the model's prediction, then compare after the edge.
    task automatic step(input bit r);
        exp_t e;
        rst = r;
        model_adv(r, MOD_A, RV_A, m_cnt_a, m_wrap_a, m_wc_a);
        model_adv(r, MOD_B, RV_B, m_cnt_b, m_wrap_b, m_wc_b);
        e.par_a  = m_cnt_a;
        e.tc_a   = (m_cnt_a == MOD_A - 1) ? 1 : 0;
        e.wrap_a = m_wrap_a;
        e.wc_a   = m_wc_a;
        e.par_b  = m_cnt_b;
        e.tc_b   = (m_cnt_b == MOD_B - 1) ? 1 : 0;
        e.wrap_b = m_wrap_b;
        e.wc_b   = m_wc_b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        compare_front();
    endtask

    initial begin
        rst = 1'b1;
        step(1'b1);
        step(1'b1);
        check_eq("reset_par_a",  int'(if_a.par_out),    0);
        check_eq("reset_tc_a",   int'(if_a.tc),         0);
        check_eq("reset_wc_a",   int'(if_a.wrap_count), 0);
        check_eq("reset_par_b",  int'(if_b.par_out),    7);
        check_eq("reset_wrap_b", int'(if_b.wrap),       0);

        wraps_a = 0;
        for (int i = 1; i <= 256; i++) begin
            step(1'b0);
            if (i <= 10) begin
                check_eq("early_par_a", int'(if_a.par_out), i);
                check_eq("early_tc_a",  int'(if_a.tc),      0);
            end
            if (i == 1) check_eq("first_par_b", int'(if_b.par_out), 8);
            if (i == 2) check_eq("tc_at9_b",    int'(if_b.tc),      1);
            if (i == 3) begin
                check_eq("wrap_par_b", int'(if_b.par_out), 0);
                check_eq("wrap_b",     int'(if_b.wrap),    1);
                check_eq("wrap_tc_b",  int'(if_b.tc),      0);
            end
            if (i == 63) begin
                check_eq("edge63_par_a", int'(if_a.par_out), 63);
                check_eq("edge63_tc_a",  int'(if_a.tc),      1);
            end
            if (i == 64) begin
                check_eq("edge64_par_a",  int'(if_a.par_out), 0);
                check_eq("edge64_tc_a",   int'(if_a.tc),      0);
                check_eq("edge64_wrap_a", int'(if_a.wrap),    1);
            end
            if (i == 65) check_eq("edge65_wrap_a", int'(if_a.wrap), 0);
            if ((i % 64) == 0) check_eq("sweep_wc_a", int'(if_a.wrap_count), (i / 64) % 4);
        end
        check_eq("wrap_pulses_a", wraps_a, 4);

        // Bring the counter to 63 with a nonzero sweep count, then reset while tc is high.
        for (int i = 0; i < 127; i++) step(1'b0);
        check_eq("pre_rst_par_a", int'(if_a.par_out),    63);
        check_eq("pre_rst_tc_a",  int'(if_a.tc),         1);
        check_eq("pre_rst_wc_a",  int'(if_a.wrap_count), 1);
        step(1'b1);
        check_eq("midrst_par_a",  int'(if_a.par_out),    0);
        check_eq("midrst_wrap_a", int'(if_a.wrap),       0);
        check_eq("midrst_wc_a",   int'(if_a.wrap_count), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            check_eq("hold_par_a", int'(if_a.par_out),    0);
            check_eq("hold_wc_a",  int'(if_a.wrap_count), 0);
            check_eq("hold_par_b", int'(if_b.par_out),    7);
        end

        // Release reset between edges: nothing may move until the next rising edge.
        #2;
        rst = 1'b0;
        #1;
        check_eq("release_hold_par_a", int'(if_a.par_out), 0);
        check_eq("release_hold_par_b", int'(if_b.par_out), 7);
        step(1'b0);
        check_eq("release_par_a", int'(if_a.par_out), 1);
        check_eq("release_par_b", int'(if_b.par_out), 8);
        for (int i = 0; i < 24; i++) step(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_6bit.md
# counter_6bit

Free-running modulo-N up-counter that generates the table address for the sine waveform generator. It steps through 0…63 once per clock, wraps to 0, and flags the last count so the quadrant state machine can advance. It also keeps a 2-bit sweep count, which gives the current quarter-wave quadrant directly. Pure sequential block with no data inputs; it sits between the clock/reset tree and the sine LUT/controller.

## Interface
Parameters:
- WIDTH, 6: counter width in bits.
- MODULUS, 64: count length; the counter runs 0…MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2**WIDTH.
- RESET_VALUE, 0: value loaded into par_out by reset. Must be < MODULUS.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- par_out  output  WIDTH  current count, registered.
- tc  output  1  terminal count: high while par_out == MODULUS-1. Combinational decode of the register only.
- wrap  output  1  registered one-cycle pulse, high in the cycle where par_out has just returned from MODULUS-1 to 0.
- wrap_count  output  2  number of completed sweeps, modulo 4 (quadrant index 0..3). Registered.

## Operation
- Reset: par_out = RESET_VALUE, wrap = 0, wrap_count = 0.
- Normal cycle (rst low):
  - If par_out == MODULUS-1: par_out ← 0, wrap ← 1, wrap_count ← wrap_count+1 (mod 4).
  - Else: par_out ← par_out+1, wrap ← 0, wrap_count holds.
- tc = (par_out == MODULUS-1). It does not depend on rst.
- Arithmetic is unsigned and WIDTH bits wide. Values ≥ MODULUS can only arise from a bad parameter; in that case the next count is 0 and it is treated as a wrap.
- wrap_count rolls over from 3 to 0 with no further indication.
- When MODULUS == 2**WIDTH, the wrap occurs by natural overflow; the behaviour is identical to the explicit compare.
- The counter has no enable: it counts on every clock edge.

## Timing
- All state changes on the rising edge of clk. Reset takes effect at the first rising edge with rst high; no asynchronous path.
- Latency: par_out changes on the edge after rst is released.
  - With RESET_VALUE = 0: first post-reset edge gives par_out = 1.
  - With defaults: tc first asserts at edge 63 after reset release. wrap asserts at edge 64 together with par_out = 0 and wrap_count = 1.
- Reset mid-count, including while tc is high: reset wins. par_out → RESET_VALUE, wrap → 0, wrap_count → 0. No wrap is counted.
- Held reset: outputs stay at their reset values every cycle. tc reflects RESET_VALUE (high only if RESET_VALUE == MODULUS-1).
- Period: tc and wrap each pulse exactly once every MODULUS cycles; wrap_count cycles every 4·MODULUS cycles.

## Structure
- Single module; no sub-modules.
- Shared sine package constants: LUT_ADDR_W = 6, LUT_DEPTH = 64, and quadrant encoding Q1..Q4 = 0..3, matching wrap_count.
- Elaboration-time checks on MODULUS and RESET_VALUE legality: fail with an error on illegal values.

## Test plan
- Reset then run 10 cycles (defaults) → par_out = 0,1,2,…,10 and tc = 0 throughout.
- Run 63 edges from reset → par_out = 63, tc = 1. Next edge → par_out = 0, tc = 0, wrap = 1, wrap_count = 1. Following edge → wrap = 0.
- Run 256 edges → wrap_count sequence 1, 2, 3, 0 at edges 64, 128, 192, 256; exactly 4 wrap pulses.
- Assert rst at par_out = 63 (tc high) → next edge gives par_out = 0, wrap = 0, wrap_count = 0. Hold rst 3 cycles → outputs stay unchanged.
- MODULUS = 10, RESET_VALUE = 7 → reset gives 7. Sequence then runs 8, 9, 0 with wrap = 1, then 1…; tc high at 9 only.
- Release rst mid-cycle (deassert between edges) → no change before the next rising edge, then par_out = RESET_VALUE+1.
